// File: rtl/debug_pkg.sv
// Shared encodings for the memory debug scanner: operating modes and
// read-FSM states, plus a small helper used when deciding scan behaviour.
package debug_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // AUTO and STEP walk the scan address; MANUAL and FREEZE do not.
  function automatic logic is_scan_mode(input mode_e m);
    return (m == MODE_AUTO) || (m == MODE_STEP);
  endfunction

endpackage

// File: rtl/debug_sync.sv
// Two-flop synchroniser for asynchronous pins (switches, pushbuttons).
// Parameterised in width so the address switches and the step button
// share the same implementation.
module debug_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // First stage captures the raw pin, second stage resolves metastability.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear on reset so nothing spurious leaves the synchroniser.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debug_scanner.sv
// Memory debug scanner: periodically (or on a button press) reads one word
// from a debug memory port and shows it on a multiplexed hex display.
// A pending-event slot lets one request queue up behind a busy read.
module debug_scanner
  import debug_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int TICK_W     = 23,
  parameter int MUX_W      = 10,
  parameter int ADDR_LIMIT = (1 << ADDR_W) - 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   sw_addr,
  input  logic                step,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W-1:0]   disp_data,
  output logic [3:0]          digit_val,
  output logic [DATA_W/4-1:0] digit_sel,
  output logic                err,
  output logic                heartbeat
);

  localparam int NIB    = DATA_W / 4;
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [MUX_W-1:0]    mux_cnt_q, mux_cnt_d;
  logic [NIB-1:0]      digit_sel_q, digit_sel_d;
  logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                pending_q, pending_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                step_prev_q, step_prev_d;
  mode_e               mode_prev_q, mode_prev_d;

  logic [ADDR_W-1:0]   sw_addr_s;
  logic [0:0]          step_s;
  mode_e               mode_cur;
  logic                tick;
  logic                step_evt;
  logic                mode_enter;
  logic                read_evt;
  logic                issue;
  logic [ADDR_W-1:0]   scan_cur;
  logic [ADDR_W-1:0]   issue_addr;

  debug_sync #(.WIDTH(ADDR_W)) u_sync_addr (
    .CLK   (CLK),
    .reset (reset),
    .d     (sw_addr),
    .q     (sw_addr_s)
  );

  debug_sync #(.WIDTH(1)) u_sync_step (
    .CLK   (CLK),
    .reset (reset),
    .d     (step),
    .q     (step_s)
  );

  assign mode_cur = mode_e'(mode);

  // Free-running refresh and display-scan counters; digit enable rotates on
  // each scan-counter wrap (the shift pair also covers a single-digit display).
  always_comb begin
    tick_cnt_d  = tick_cnt_q + 1'b1;
    mux_cnt_d   = mux_cnt_q + 1'b1;
    tick        = &tick_cnt_q;
    digit_sel_d = digit_sel_q;
    if (&mux_cnt_q) begin
      digit_sel_d = (digit_sel_q << 1) | (digit_sel_q >> (NIB - 1));
    end
  end

  // Turn tick / step edges into read events and pick the address a read
  // would use right now; entering a scan mode restarts the walk at 0.
  always_comb begin
    step_prev_d = step_s[0];
    mode_prev_d = mode_cur;
    step_evt    = step_s[0] & ~step_prev_q;
    mode_enter  = (mode_cur != mode_prev_q) && is_scan_mode(mode_cur);
    read_evt    = 1'b0;
    case (mode_cur)
      MODE_MANUAL: read_evt = tick;
      MODE_AUTO:   read_evt = tick;
      MODE_STEP:   read_evt = step_evt;
      MODE_FREEZE: read_evt = 1'b0;
    endcase
    scan_cur   = mode_enter ? '0 : scan_addr_q;
    issue_addr = (mode_cur == MODE_MANUAL) ? sw_addr_s : scan_cur;
    issue      = (state_q == ST_IDLE) && (read_evt || pending_q)
                 && (mode_cur != MODE_FREEZE);
  end

  // Read FSM with its datapath: launch, hold the address, capture data or
  // give up after the timeout, and keep at most one event queued.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_addr_d  = mem_addr_q;
    scan_addr_d = scan_cur;
    disp_data_d = disp_data_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    pending_d   = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d    = ST_REQ;
          mem_addr_d = issue_addr;
          pending_d  = 1'b0;
          if (is_scan_mode(mode_cur)) begin
            scan_addr_d = (scan_cur == ADDR_W'(ADDR_LIMIT)) ? '0 : scan_cur + 1'b1;
          end
        end
      end
      ST_REQ: begin
        mem_req    = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (mem_valid) begin
          disp_data_d = mem_data;
          err_d       = 1'b0;
          state_d     = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && read_evt) begin
      pending_d = 1'b1;
    end
    if (mode_cur == MODE_FREEZE) begin
      pending_d = 1'b0;
    end
  end

  // Select the nibble of the displayed word that the active digit shows.
  always_comb begin
    digit_val = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (digit_sel_q[i]) begin
        digit_val = disp_data_q[4*i +: 4];
      end
    end
  end

  // State register; reset abandons any read in flight.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      mux_cnt_q   <= '0;
      digit_sel_q <= NIB'(1);
      scan_addr_q <= '0;
      mem_addr_q  <= '0;
      pending_q   <= 1'b0;
      disp_data_q <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      step_prev_q <= 1'b0;
      mode_prev_q <= MODE_MANUAL;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      mux_cnt_q   <= mux_cnt_d;
      digit_sel_q <= digit_sel_d;
      scan_addr_q <= scan_addr_d;
      mem_addr_q  <= mem_addr_d;
      pending_q   <= pending_d;
      disp_data_q <= disp_data_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
      step_prev_q <= step_prev_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign disp_data = disp_data_q;
  assign digit_sel = digit_sel_q;
  assign err       = err_q;
  assign heartbeat = tick_cnt_q[TICK_W-1];

endmodule

// File: tb/tb_debug_scanner.sv
// Directed bench for debug_scanner with a small latency-programmable
// memory model. Fast tick / scan periods keep the run short.
module tb_debug_scanner;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int TICK_W     = 4;
  localparam int MUX_W      = 2;
  localparam int ADDR_LIMIT = 3;
  localparam int TIMEOUT    = 15;

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_AUTO   = 2'b01;
  localparam logic [1:0] M_STEP   = 2'b10;
  localparam logic [1:0] M_FREEZE = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] sw_addr;
  logic              step;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] disp_data;
  logic [3:0]        digit_val;
  logic [1:0]        digit_sel;
  logic              err;
  logic              heartbeat;

  logic [7:0] mem [16];
  logic       model_en = 1'b1;
  logic       late_en  = 1'b0;
  int         latency  = 2;
  int         lat_cnt  = 0;
  int         req_total = 0;

  int errors = 0;
  int checks = 0;

  debug_scanner #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_W(TICK_W), .MUX_W(MUX_W),
    .ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK       (clk),
    .reset     (reset),
    .mode      (mode),
    .sw_addr   (sw_addr),
    .step      (step),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .disp_data (disp_data),
    .digit_val (digit_val),
    .digit_sel (digit_sel),
    .err       (err),
    .heartbeat (heartbeat)
  );

  always #5 clk = ~clk;

  // Memory model: answers a request 'latency' negedges later, can be muted,
  // and can inject a stray strobe; also counts every request cycle seen.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (late_en) begin
      mem_valid = 1'b1;
      mem_data  = 8'hFF;
    end else if (lat_cnt == 1) begin
      mem_valid = 1'b1;
      mem_data  = mem[mem_addr];
    end
    if (lat_cnt > 0) lat_cnt--;
    if (mem_req) begin
      req_total++;
      if (model_en) lat_cnt = latency;
    end
  end

  // Global time limit so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [ADDR_W-1:0] a, input logic s);
    mode    = m;
    sw_addr = a;
    step    = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (!mem_req && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, 32'(mem_req), 32'd1);
  endtask

  initial begin
    int exp_addr [5];
    int exp_data [5];
    int base;
    int toggles;
    logic hb_prev;

    exp_addr = '{0, 1, 2, 3, 0};
    exp_data = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[3] = 8'h43; mem[5] = 8'hA7;

    // Reset state
    reset = 1'b0;
    applyStimulus(M_MANUAL, 4'h5, 1'b0);
    waitCycles(3);
    $display("[TB] reset values");
    checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
    checkOutput("rst_mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("rst_disp_data", 32'(disp_data), 32'd0);
    checkOutput("rst_err",       32'(err),       32'd0);
    checkOutput("rst_digit_sel", 32'(digit_sel), 32'd1);
    checkOutput("rst_heartbeat", 32'(heartbeat), 32'd0);
    checkOutput("rst_digit_val", 32'(digit_val), 32'd0);
    reset = 1'b1;

    // MANUAL read of switch address 5
    $display("[TB] manual mode");
    waitReq("man_req_seen");
    checkOutput("man_addr", 32'(mem_addr), 32'h5);
    waitCycles(4);
    checkOutput("man_disp", 32'(disp_data), 32'hA7);
    checkOutput("man_err",  32'(err),       32'd0);
    for (int n = 0; n < 8 && digit_sel != 2'b01; n++) waitCycles(1);
    checkOutput("dig_low_sel", 32'(digit_sel), 32'd1);
    checkOutput("dig_low_val", 32'(digit_val), 32'h7);
    for (int n = 0; n < 8 && digit_sel == 2'b01; n++) waitCycles(1);
    checkOutput("dig_high_sel", 32'(digit_sel), 32'd2);
    checkOutput("dig_high_val", 32'(digit_val), 32'hA);
    for (int n = 0; n < 8 && digit_sel == 2'b10; n++) waitCycles(1);
    checkOutput("dig_wrap_sel", 32'(digit_sel), 32'd1);

    // AUTO walk 0..3 then wrap
    $display("[TB] auto mode");
    applyStimulus(M_AUTO, 4'h5, 1'b0);
    waitCycles(1);
    for (int k = 0; k < 5; k++) begin
      waitReq($sformatf("auto_req_seen_%0d", k));
      checkOutput($sformatf("auto_addr_%0d", k), 32'(mem_addr), 32'(exp_addr[k]));
      waitCycles(4);
      checkOutput($sformatf("auto_disp_%0d", k), 32'(disp_data), 32'(exp_data[k]));
    end

    // Timeout: model silent, err exactly TIMEOUT+1 cycles after the request
    $display("[TB] timeout");
    model_en = 1'b0;
    waitReq("to_req_seen");
    checkOutput("to_addr", 32'(mem_addr), 32'd1);
    waitCycles(TIMEOUT);
    checkOutput("to_err_early", 32'(err),      32'd0);
    checkOutput("to_addr_hold", 32'(mem_addr), 32'd1);
    waitCycles(1);
    checkOutput("to_err_set",   32'(err),       32'd1);
    checkOutput("to_disp_keep", 32'(disp_data), 32'h10);
    model_en = 1'b1;
    waitReq("rec_req_seen");
    checkOutput("rec_addr", 32'(mem_addr), 32'd2);
    waitCycles(4);
    checkOutput("rec_disp", 32'(disp_data), 32'h32);
    checkOutput("rec_err",  32'(err),       32'd0);

    // STEP: three button edges during one long read give two reads
    $display("[TB] step mode");
    latency = 12;
    applyStimulus(M_STEP, 4'h5, 1'b0);
    waitCycles(24);
    base = req_total;
    repeat (3) begin
      applyStimulus(M_STEP, 4'h5, 1'b1);
      waitCycles(3);
      applyStimulus(M_STEP, 4'h5, 1'b0);
      waitCycles(3);
    end
    waitCycles(40);
    checkOutput("step_reads", 32'(req_total - base), 32'd2);
    checkOutput("step_disp",  32'(disp_data),        32'h21);

    // FREEZE drops the queued event but lets the outstanding read finish
    $display("[TB] freeze mode");
    base = req_total;
    applyStimulus(M_STEP, 4'h5, 1'b1);
    waitCycles(3);
    applyStimulus(M_STEP, 4'h5, 1'b0);
    waitCycles(3);
    applyStimulus(M_STEP, 4'h5, 1'b1);
    waitCycles(3);
    applyStimulus(M_FREEZE, 4'h5, 1'b0);
    waitCycles(30);
    checkOutput("frz_reads", 32'(req_total - base), 32'd1);
    checkOutput("frz_disp",  32'(disp_data),        32'h32);
    base    = req_total;
    toggles = 0;
    hb_prev = heartbeat;
    for (int n = 0; n < 64; n++) begin
      waitCycles(1);
      if (heartbeat !== hb_prev) toggles++;
      hb_prev = heartbeat;
    end
    checkOutput("frz_no_req",     32'(req_total - base), 32'd0);
    checkOutput("frz_hb_toggles", 32'(toggles),          32'd8);

    // Reset during WAIT, then a stray strobe after release
    $display("[TB] reset in wait");
    latency  = 2;
    model_en = 1'b0;
    applyStimulus(M_MANUAL, 4'h5, 1'b0);
    waitReq("rw_req_seen");
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("rw_disp_rst", 32'(disp_data), 32'd0);
    checkOutput("rw_addr_rst", 32'(mem_addr),  32'd0);
    reset = 1'b1;
    base    = req_total;
    late_en = 1'b1;
    waitCycles(2);
    late_en = 1'b0;
    waitCycles(6);
    checkOutput("rw_disp_late", 32'(disp_data),        32'd0);
    checkOutput("rw_err_late",  32'(err),              32'd0);
    checkOutput("rw_no_req",    32'(req_total - base), 32'd0);
    model_en = 1'b1;
    waitReq("rw_next_req_seen");
    checkOutput("rw_next_addr", 32'(mem_addr), 32'h5);
    waitCycles(4);
    checkOutput("rw_next_disp", 32'(disp_data), 32'hA7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
